// File: rtl/f_less_or_equal_seq.sv
// rtl/f_less_or_equal_seq.sv - multi-cycle IEEE-754 "a <= b" responder, chunked MSB-first magnitude scan
// Optional macro F_LESS_OR_EQUAL_SEQ_FIXED_LATENCY_EN: every request takes 2+NCHUNK cycles.
`ifndef FLEN
`define FLEN 64
`endif

module f_less_or_equal_seq #(
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [`FLEN-1:0] a,
  input  logic [`FLEN-1:0] b,
  output logic             valid_out,
  output logic             res,
  output logic             err,
  output logic             busy
);
  localparam int FLEN   = `FLEN;
  localparam int NCHUNK = (FLEN - 1 + CHUNK - 1) / CHUNK;
  localparam int MW     = NCHUNK * CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int EW     = (FLEN == 16) ? 5 : (FLEN == 32) ? 8 : 11;
  localparam int FW     = FLEN - 1 - EW;

  typedef enum logic [1:0] {IDLE, CLASSIFY, SCAN, DONE} state_t;

  state_t          state_q, state_d;
  logic [FLEN-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            valid_out_q, valid_out_d;
  logic            res_q, res_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
`ifdef F_LESS_OR_EQUAL_SEQ_FIXED_LATENCY_EN
  logic            dec_q, dec_d;
  logic            dres_q, dres_d;
  logic            derr_q, derr_d;
`endif

  logic [MW-1:0]    mag_a, mag_b;
  logic [CHUNK-1:0] slice_a, slice_b;
  logic             nan_a, nan_b, both_zero, sign_a, sign_b;
  logic             cls_hit, cls_res, cls_err;
  logic             last, diff, scan_res;

  always_comb begin
    mag_a     = MW'(a_q[FLEN-2:0]);
    mag_b     = MW'(b_q[FLEN-2:0]);
    slice_a   = CHUNK'(mag_a >> (CHUNK * (NCHUNK - 1 - int'(idx_q))));
    slice_b   = CHUNK'(mag_b >> (CHUNK * (NCHUNK - 1 - int'(idx_q))));
    sign_a    = a_q[FLEN-1];
    sign_b    = b_q[FLEN-1];
    nan_a     = (&a_q[FLEN-2 -: EW]) && (|a_q[FW-1:0]);
    nan_b     = (&b_q[FLEN-2 -: EW]) && (|b_q[FW-1:0]);
    both_zero = ~|a_q[FLEN-2:0] && ~|b_q[FLEN-2:0];

    cls_hit = 1'b1;
    cls_res = 1'b0;
    cls_err = 1'b0;
    if (nan_a || nan_b) begin
      cls_err = 1'b1;
    end else if (both_zero) begin
      cls_res = 1'b1;
    end else if (sign_a != sign_b) begin
      cls_res = sign_a;
    end else begin
      cls_hit = 1'b0;
    end

    // Signs are equal whenever SCAN runs, so a differing slice alone decides the order.
    last     = (idx_q == IW'(NCHUNK - 1));
    diff     = (slice_a != slice_b);
    scan_res = diff ? (sign_a ? (slice_a > slice_b) : (slice_a < slice_b)) : 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    valid_out_d = 1'b0;
    res_d       = res_q;
    err_d       = err_q;
`ifdef F_LESS_OR_EQUAL_SEQ_FIXED_LATENCY_EN
    dec_d       = dec_q;
    dres_d      = dres_q;
    derr_d      = derr_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          a_d     = a;
          b_d     = b;
          state_d = CLASSIFY;
        end
      end
      CLASSIFY: begin
        idx_d = '0;
`ifdef F_LESS_OR_EQUAL_SEQ_FIXED_LATENCY_EN
        dec_d   = cls_hit;
        dres_d  = cls_res;
        derr_d  = cls_err;
        state_d = SCAN;
`else
        if (cls_hit) begin
          res_d       = cls_res;
          err_d       = cls_err;
          valid_out_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = SCAN;
        end
`endif
      end
      SCAN: begin
`ifdef F_LESS_OR_EQUAL_SEQ_FIXED_LATENCY_EN
        if (!dec_q && diff) begin
          dec_d  = 1'b1;
          dres_d = scan_res;
          derr_d = 1'b0;
        end
        if (last) begin
          res_d       = dec_q ? dres_q : scan_res;
          err_d       = dec_q ? derr_q : 1'b0;
          valid_out_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
`else
        if (diff || last) begin
          res_d       = scan_res;
          err_d       = 1'b0;
          valid_out_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      valid_out_q <= 1'b0;
      res_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef F_LESS_OR_EQUAL_SEQ_FIXED_LATENCY_EN
      dec_q       <= 1'b0;
      dres_q      <= 1'b0;
      derr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      valid_out_q <= valid_out_d;
      res_q       <= res_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
`ifdef F_LESS_OR_EQUAL_SEQ_FIXED_LATENCY_EN
      dec_q       <= dec_d;
      dres_q      <= dres_d;
      derr_q      <= derr_d;
`endif
    end
  end

  assign valid_out = valid_out_q;
  assign res       = res_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_f_less_or_equal_seq.sv
// tb/tb_f_less_or_equal_seq.sv - randomized self-checking bench for f_less_or_equal_seq
`ifndef FLEN
`define FLEN 64
`endif

module tb_f_less_or_equal_seq;
  localparam int CHUNK  = 16;
  localparam int NCHUNK = (63 + CHUNK - 1) / CHUNK;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [63:0] a_i, b_i;
  logic        valid_out, res, err, busy;

  int n_vec  = 0;
  int n_miss = 0;

  f_less_or_equal_seq #(.CHUNK(CHUNK)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .a        (a_i),
    .b        (b_i),
    .valid_out(valid_out),
    .res      (res),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic is_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
  endfunction

  // Reference: ordering from whole-value arithmetic; latency from the first differing CHUNK group.
  task automatic ref_model(input logic [63:0] x, input logic [63:0] y,
                           output logic r, output logic e, output int lat);
    logic [63:0] mx, my;
    mx  = {1'b0, x[62:0]};
    my  = {1'b0, y[62:0]};
    r   = 1'b0;
    e   = 1'b0;
    lat = 2;
    if (is_nan(x) || is_nan(y)) begin
      e = 1'b1;
    end else if (mx == 0 && my == 0) begin
      r = 1'b1;
    end else if (x[63] != y[63]) begin
      r = x[63];
    end else begin
      r   = x[63] ? (mx >= my) : (mx <= my);
      lat = 2 + NCHUNK;
      for (int i = NCHUNK - 1; i >= 0; i--) begin
        if ((mx / (64'd1 << (CHUNK * (NCHUNK - 1 - i)))) != (my / (64'd1 << (CHUNK * (NCHUNK - 1 - i)))))
          lat = 3 + i;
      end
    end
`ifdef F_LESS_OR_EQUAL_SEQ_FIXED_LATENCY_EN
    lat = 2 + NCHUNK;
`endif
  endtask

  task automatic run_req(input string tag, input logic [63:0] x, input logic [63:0] y);
    logic er, ee;
    int   el, n;
    bit   seen;
    ref_model(x, y, er, ee, el);
    @(negedge clk);
    valid_in = 1'b1;
    a_i      = x;
    b_i      = y;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    n    = 1;
    seen = 0;
    if (valid_out) seen = 1;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (valid_out) seen = 1;
    end
    check({tag, "_lat"}, seen ? n : 0, el);
    check({tag, "_res"}, res, er);
    check({tag, "_err"}, err, ee);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, {busy, valid_out}, 2'b00);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] special(input int k);
    case (k % 8)
      0: return 64'h0000000000000000;
      1: return 64'h8000000000000000;
      2: return 64'h7FF0000000000000;
      3: return 64'hFFF0000000000000;
      4: return 64'h7FF8000000000000;
      5: return 64'h3FF0000000000000;
      6: return 64'hBFF0000000000000;
      default: return 64'h0000000000000001;
    endcase
  endfunction

  initial begin
    int          pulses, idx;
    logic [63:0] x, y;
    rst      = 1'b1;
    valid_in = 1'b0;
    a_i      = '0;
    b_i      = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {valid_out, res, err, busy}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    run_req("one_two",   64'h3FF0000000000000, 64'h4000000000000000);
    run_req("eq_neg",    64'hC00C000000000000, 64'hC00C000000000000);
    run_req("neg1_neg2", 64'hBFF0000000000000, 64'hC000000000000000);
    run_req("neg2_neg1", 64'hC000000000000000, 64'hBFF0000000000000);
    run_req("pz_nz",     64'h0000000000000000, 64'h8000000000000000);
    run_req("neg1_pz",   64'hBFF0000000000000, 64'h0000000000000000);
    run_req("pz_neg1",   64'h0000000000000000, 64'hBFF0000000000000);
    run_req("nan_one",   64'h7FF8000000000000, 64'h3FF0000000000000);
    run_req("inf_one",   64'h7FF0000000000000, 64'h3FF0000000000000);
    run_req("last_diff", 64'h4000000000000001, 64'h4000000000000000);

    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 4))
        0: begin x = rnd64(); y = rnd64(); end
        1: begin x = special($urandom()); y = special($urandom()); end
        2: begin x = rnd64(); y = x ^ (64'd1 << $urandom_range(0, 62)); end
        3: begin x = rnd64(); y = {x[63], rnd64() & 64'h7FFF_FFFF_FFFF_FFFF}; end
        default: begin x = rnd64(); y = x; end
      endcase
      run_req("rand", x, y);
    end

    // Extra strobes while busy must be ignored.
    @(negedge clk);
    valid_in = 1'b1;
    a_i      = 64'hC00C000000000000;
    b_i      = 64'hC00C000000000000;
    pulses   = 0;
    idx      = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        a_i = 64'h7FF8000000000000;
        b_i = 64'h3FF0000000000000;
      end
      if (c == 4) valid_in = 1'b0;
      if (valid_out) begin
        pulses++;
        idx = c;
        check("busy_res", {res, err}, 2'b10);
      end
    end
    check("busy_pulses", pulses, 1);
    check("busy_lat", idx, 2 + NCHUNK);

    // Reset during SCAN aborts with no pulse.
    @(negedge clk);
    valid_in = 1'b1;
    a_i      = 64'hC00C000000000000;
    b_i      = 64'hC00C000000000000;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_abort", {valid_out, res, err, busy}, 4'b0000);
    rst    = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (valid_out) pulses++;
    end
    check("rst_no_pulse", pulses, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
